// File: rtl/cin_pkg.sv
// rtl/cin_pkg.sv - carry-in source select encodings and size limits
package cin_pkg;

    localparam int CIN_SEL_W = 3;
    localparam int MAX_LANES = 8;
    localparam int MAX_DEPTH = 4;

    localparam logic [CIN_SEL_W-1:0] CIN_SEL_ZERO  = 3'd0;
    localparam logic [CIN_SEL_W-1:0] CIN_SEL_ONE   = 3'd1;
    localparam logic [CIN_SEL_W-1:0] CIN_SEL_EXT   = 3'd2;
    localparam logic [CIN_SEL_W-1:0] CIN_SEL_OPM5  = 3'd3;
    localparam logic [CIN_SEL_W-1:0] CIN_SEL_FB    = 3'd4;
    localparam logic [CIN_SEL_W-1:0] CIN_SEL_CHAIN = 3'd5;

endpackage

// File: rtl/cin_pipe_stage.sv
// rtl/cin_pipe_stage.sv - one carry pipeline stage: {valid, carries} register
module cin_pipe_stage #(
    parameter int W = 2
) (
    input  logic         CLK,
    input  logic         RSTN,
    input  logic         RST,
    input  logic         CE,
    input  logic [W-1:0] D,
    output logic [W-1:0] Q
);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            Q <= '0;
        end else if (RST) begin
            Q <= '0;
        end else if (CE) begin
            Q <= D;
        end
    end

endmodule

// File: rtl/carryin_pipe.sv
// rtl/carryin_pipe.sv - multi-lane carry-in source mux, feedback regs and DEPTH-stage pipe
// Define CARRYIN_FWD_EN to bypass same-cycle CARRYOUT into the FB/CHAIN sources.
module carryin_pipe
    import cin_pkg::*;
#(
    parameter int LANES = 1,
    parameter int DEPTH = 1
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    input  logic                 RSTCARRYIN,
    input  logic                 CECARRYIN,
    input  logic [CIN_SEL_W-1:0] SEL,
    input  logic [LANES-1:0]     CARRYIN,
    input  logic                 OPMODE5,
    input  logic                 IN_VALID,
    input  logic [LANES-1:0]     CARRYOUT,
    input  logic                 CARRYOUT_VLD,
    input  logic                 CARRYOUT_CLR,
    output logic [LANES-1:0]     CIN,
    output logic                 OUT_VALID,
    output logic [LANES-1:0]     FB_CARRY
);

    logic [LANES-1:0] fb_q;
    logic [LANES-1:0] fb;
    logic [LANES-1:0] chain;
    logic [LANES-1:0] sel_vec;
    logic [LANES:0]   pipe [DEPTH+1];

    // Feedback registers run independently of the pipeline clock enable.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            fb_q <= '0;
        end else if (RSTCARRYIN) begin
            fb_q <= '0;
        end else if (CARRYOUT_CLR) begin
            fb_q <= '0;
        end else if (CARRYOUT_VLD) begin
            fb_q <= CARRYOUT;
        end
    end

    assign FB_CARRY = fb_q;

`ifdef CARRYIN_FWD_EN
    assign fb = (CARRYOUT_VLD && !CARRYOUT_CLR) ? CARRYOUT : fb_q;
`else
    assign fb = fb_q;
`endif

    // Chaining: each lane takes the previous lane's carry-out, lane 0 the external carry.
    assign chain[0] = CARRYIN[0];
    for (genvar i = 1; i < LANES; i++) begin : g_chain
        assign chain[i] = fb[i-1];
    end

    always_comb begin
        sel_vec = '0;
        case (SEL)
            CIN_SEL_ONE:   sel_vec = '1;
            CIN_SEL_EXT:   sel_vec = CARRYIN;
            CIN_SEL_OPM5:  sel_vec = {LANES{OPMODE5}};
            CIN_SEL_FB:    sel_vec = fb;
            CIN_SEL_CHAIN: sel_vec = chain;
            default:       sel_vec = '0;
        endcase
    end

    assign pipe[0] = {IN_VALID, sel_vec};

    for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
        cin_pipe_stage #(.W(LANES + 1)) u_stage (
            .CLK  (CLK),
            .RSTN (RSTN),
            .RST  (RSTCARRYIN),
            .CE   (CECARRYIN),
            .D    (pipe[k-1]),
            .Q    (pipe[k])
        );
    end

    assign CIN       = pipe[DEPTH][LANES-1:0];
    assign OUT_VALID = pipe[DEPTH][LANES];

endmodule

// File: tb/tb_carryin_pipe.sv
// tb/tb_carryin_pipe.sv - directed self-checking bench: DEPTH=2 and DEPTH=0 instances, LANES=4
module tb_carryin_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rstcarryin;
    logic       cecarryin;
    logic [2:0] sel;
    logic [3:0] carryin;
    logic       opmode5;
    logic       in_valid;
    logic [3:0] carryout;
    logic       carryout_vld;
    logic       carryout_clr;

    logic [3:0] cin2, fb2, cin0, fb0;
    logic       vld2, vld0;

    int checks   = 0;
    int failures = 0;

    logic [3:0] sweep_exp [8];
    logic [3:0] ce_vals [4];
    logic [3:0] fwd_exp;

    always #5 clk = ~clk;

    carryin_pipe #(.LANES(4), .DEPTH(2)) dut (
        .CLK(clk), .RSTN(rst_n), .RSTCARRYIN(rstcarryin), .CECARRYIN(cecarryin),
        .SEL(sel), .CARRYIN(carryin), .OPMODE5(opmode5), .IN_VALID(in_valid),
        .CARRYOUT(carryout), .CARRYOUT_VLD(carryout_vld), .CARRYOUT_CLR(carryout_clr),
        .CIN(cin2), .OUT_VALID(vld2), .FB_CARRY(fb2)
    );

    carryin_pipe #(.LANES(4), .DEPTH(0)) dut0 (
        .CLK(clk), .RSTN(rst_n), .RSTCARRYIN(rstcarryin), .CECARRYIN(cecarryin),
        .SEL(sel), .CARRYIN(carryin), .OPMODE5(opmode5), .IN_VALID(in_valid),
        .CARRYOUT(carryout), .CARRYOUT_VLD(carryout_vld), .CARRYOUT_CLR(carryout_clr),
        .CIN(cin0), .OUT_VALID(vld0), .FB_CARRY(fb0)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; rstcarryin = 1'b0; cecarryin = 1'b1; sel = 3'd0;
        carryin = 4'b0; opmode5 = 1'b0; in_valid = 1'b0;
        carryout = 4'b0; carryout_vld = 1'b0; carryout_clr = 1'b0;
`ifdef CARRYIN_FWD_EN
        fwd_exp = 4'b0011;
`else
        fwd_exp = 4'b0000;
`endif
        sweep_exp = '{4'b0000, 4'b1111, 4'b1010, 4'b1111, 4'b0110, 4'b1100, 4'b0000, 4'b0000};
        ce_vals   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

        // Reset state
        step(); step();
        check("rst_cin", cin2, 4'b0000);
        check("rst_vld", vld2, 1'b0);
        check("rst_fb", fb2, 4'b0000);

        // Two-cycle latency of a single valid ONE
        rst_n = 1'b1; sel = 3'd1; in_valid = 1'b1;
        step();
        check("lat1_vld", vld2, 1'b0);
        sel = 3'd0; in_valid = 1'b0;
        step();
        check("lat2_cin", cin2, 4'b1111);
        check("lat2_vld", vld2, 1'b1);
        step();
        check("lat3_vld", vld2, 1'b0);

        // Load feedback with 0110, then sweep every select code
        carryout = 4'b0110; carryout_vld = 1'b1;
        step();
        carryout_vld = 1'b0; carryout = 4'b0;
        check("fb_load", fb2, 4'b0110);
        carryin = 4'b1010; opmode5 = 1'b1;
        for (int k = 0; k < 9; k++) begin
            if (k < 8) begin
                sel = 3'(k); in_valid = 1'b1;
                #1;
                check($sformatf("d0_sel%0d", k), cin0, sweep_exp[k]);
                check($sformatf("d0_vld%0d", k), vld0, 1'b1);
            end else begin
                sel = 3'd0; in_valid = 1'b0;
            end
            step();
            if (k >= 1) begin
                check($sformatf("sweep_cin%0d", k - 1), cin2, sweep_exp[k-1]);
                check($sformatf("sweep_vld%0d", k - 1), vld2, 1'b1);
            end
        end

        // Clear beats a same-cycle capture
        in_valid = 1'b0; carryout = 4'b1111; carryout_vld = 1'b1; carryout_clr = 1'b1;
        step();
        check("clr_wins", fb2, 4'b0000);
        carryout = 4'b0110; carryout_clr = 1'b0;
        step();
        check("fb_reload", fb2, 4'b0110);
        carryout_vld = 1'b0; carryout = 4'b0;

        // Chain: lane0 = CARRYIN[0], lanes1..3 = fb[0..2]
        sel = 3'd5; carryin = 4'b0001; in_valid = 1'b1;
        #1;
        check("d0_chain", cin0, 4'b1101);
        step();
        in_valid = 1'b0; sel = 3'd0;
        step();
        check("chain_cin", cin2, 4'b1101);
        check("chain_vld", vld2, 1'b1);

        // Clock-enable hold: stream of EXT values frozen for three cycles
        sel = 3'd2; in_valid = 1'b1; carryin = ce_vals[0];
        step();
        carryin = ce_vals[1];
        step();
        check("ce_pre", cin2, ce_vals[0]);
        cecarryin = 1'b0; carryin = 4'b1111;
        for (int h = 0; h < 3; h++) begin
            step();
            check($sformatf("ce_hold_cin%0d", h), cin2, ce_vals[0]);
            check($sformatf("ce_hold_vld%0d", h), vld2, 1'b1);
        end
        cecarryin = 1'b1; carryin = ce_vals[2];
        step();
        check("ce_res1", cin2, ce_vals[1]);
        carryin = ce_vals[3];
        step();
        check("ce_res2", cin2, ce_vals[2]);
        in_valid = 1'b0; carryin = 4'b0;
        step();
        check("ce_res3", cin2, ce_vals[3]);
        check("ce_res3_vld", vld2, 1'b1);
        step();
        check("ce_drain_vld", vld2, 1'b0);

        // Synchronous RSTCARRYIN discards in-flight carries and feedback
        sel = 3'd1; in_valid = 1'b1;
        step(); step();
        check("pre_rst_vld", vld2, 1'b1);
        check("pre_rst_fb", fb2, 4'b0110);
        rstcarryin = 1'b1;
        step();
        check("srst_cin", cin2, 4'b0000);
        check("srst_vld", vld2, 1'b0);
        check("srst_fb", fb2, 4'b0000);
        rstcarryin = 1'b0; in_valid = 1'b0; sel = 3'd0;
        step();
        check("srst_flush_vld", vld2, 1'b0);

        // Forwarding of same-cycle CARRYOUT into the FB source
        sel = 3'd4; carryout = 4'b0011; carryout_vld = 1'b1; in_valid = 1'b1;
        #1;
        check("d0_fwd", cin0, fwd_exp);
        step();
        check("fwd_fb", fb2, 4'b0011);
        carryout_vld = 1'b0; in_valid = 1'b0; sel = 3'd0;
        step();
        check("fwd_cin", cin2, fwd_exp);
        check("fwd_vld", vld2, 1'b1);

        // Async reset mid-stream
        sel = 3'd1; in_valid = 1'b1;
        step(); step();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_vld", vld2, 1'b0);
        check("arst_cin", cin2, 4'b0000);
        check("arst_fb", fb2, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
